// File: rtl/fwrisc_csr_rmw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : fwrisc_csr_pkg                                             |
// | Brief   : CSR numbers, register-file addresses, op and state codes   |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package fwrisc_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_DEP_LO    = 12'h7C0;
  localparam logic [11:0] CSR_DEP_HI    = 12'h7C1;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // CSRs live in the upper half of the 64-entry register file
  localparam logic [5:0] RF_MSTATUS   = 6'h20;
  localparam logic [5:0] RF_MISA      = 6'h21;
  localparam logic [5:0] RF_MIE       = 6'h22;
  localparam logic [5:0] RF_MTVEC     = 6'h23;
  localparam logic [5:0] RF_MSCRATCH  = 6'h24;
  localparam logic [5:0] RF_MEPC      = 6'h25;
  localparam logic [5:0] RF_MCAUSE    = 6'h26;
  localparam logic [5:0] RF_MTVAL     = 6'h27;
  localparam logic [5:0] RF_MIP       = 6'h28;
  localparam logic [5:0] RF_MCYCLE    = 6'h29;
  localparam logic [5:0] RF_MINSTRET  = 6'h2A;
  localparam logic [5:0] RF_MCYCLEH   = 6'h2B;
  localparam logic [5:0] RF_MINSTRETH = 6'h2C;
  localparam logic [5:0] RF_MVENDORID = 6'h2D;
  localparam logic [5:0] RF_MARCHID   = 6'h2E;
  localparam logic [5:0] RF_MIMPID    = 6'h2F;
  localparam logic [5:0] RF_MHARTID   = 6'h30;
  localparam logic [5:0] RF_DEP_LO    = 6'h31;
  localparam logic [5:0] RF_DEP_HI    = 6'h32;

  typedef enum logic [2:0] {
    OP_ILL0 = 3'b000,
    OP_RW   = 3'b001,
    OP_RS   = 3'b010,
    OP_RC   = 3'b011,
    OP_ILL4 = 3'b100,
    OP_RWI  = 3'b101,
    OP_RSI  = 3'b110,
    OP_RCI  = 3'b111
  } csr_op_e;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_CAPT   = 3'd2;
  localparam logic [2:0] ST_WR_CSR = 3'd3;
  localparam logic [2:0] ST_WR_GPR = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // kind is funct3[1:0]: 01 write, 10 set, 11 clear
  function automatic logic [31:0] csr_apply(input logic [1:0]  kind,
                                            input logic [31:0] old_val,
                                            input logic [31:0] rs1_val);
    case (kind)
      2'b01:   return rs1_val;
      2'b10:   return old_val | rs1_val;
      default: return old_val & ~rs1_val;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwrisc_csr_rmw_map.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fwrisc_csr_map                                              |
// | Brief  : 12-bit CSR number to 6-bit register-file address decoder    |
// | Rev    : 1.0                                                        |
// +----------------------------------------------------------------------+
module fwrisc_csr_map
  import fwrisc_csr_pkg::*;
#(
  parameter bit ENABLE_COUNTERS = 1'b1,
  parameter bit ENABLE_DEP      = 1'b0
) (
  input  logic [11:0] i_csr,
  output logic        o_hit,
  output logic [5:0]  o_addr,
  output logic        o_ro
);

  always_comb begin
    o_hit  = 1'b1;
    o_addr = 6'd0;
    case (i_csr)
      CSR_MSTATUS:   o_addr = RF_MSTATUS;
      CSR_MISA:      o_addr = RF_MISA;
      CSR_MIE:       o_addr = RF_MIE;
      CSR_MTVEC:     o_addr = RF_MTVEC;
      CSR_MSCRATCH:  o_addr = RF_MSCRATCH;
      CSR_MEPC:      o_addr = RF_MEPC;
      CSR_MCAUSE:    o_addr = RF_MCAUSE;
      CSR_MTVAL:     o_addr = RF_MTVAL;
      CSR_MIP:       o_addr = RF_MIP;
      CSR_MVENDORID: o_addr = RF_MVENDORID;
      CSR_MARCHID:   o_addr = RF_MARCHID;
      CSR_MIMPID:    o_addr = RF_MIMPID;
      CSR_MHARTID:   o_addr = RF_MHARTID;
      CSR_MCYCLE: begin
        o_addr = RF_MCYCLE;
        o_hit  = ENABLE_COUNTERS;
      end
      CSR_MINSTRET: begin
        o_addr = RF_MINSTRET;
        o_hit  = ENABLE_COUNTERS;
      end
      CSR_MCYCLEH: begin
        o_addr = RF_MCYCLEH;
        o_hit  = ENABLE_COUNTERS;
      end
      CSR_MINSTRETH: begin
        o_addr = RF_MINSTRETH;
        o_hit  = ENABLE_COUNTERS;
      end
      CSR_DEP_LO: begin
        o_addr = RF_DEP_LO;
        o_hit  = ENABLE_DEP;
      end
      CSR_DEP_HI: begin
        o_addr = RF_DEP_HI;
        o_hit  = ENABLE_DEP;
      end
      default: o_hit = 1'b0;
    endcase
  end

  // Top two bits 11 mark the architecturally read-only CSR range
  assign o_ro = (i_csr[11:10] == 2'b11);

endmodule
`default_nettype wire

// File: rtl/fwrisc_csr_rmw.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fwrisc_csr_rmw                                              |
// | Brief  : Zicsr read-modify-write sequencer on the register-file port |
// | Rev    : 1.0                                                        |
// +----------------------------------------------------------------------+
module fwrisc_csr_rmw
  import fwrisc_csr_pkg::*;
#(
  parameter bit ENABLE_COUNTERS = 1'b1,
  parameter bit ENABLE_DEP      = 1'b0,
  parameter bit RV32E           = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_csr,
  input  logic [31:0] req_rs1_data,
  input  logic        req_rs1_zero,
  input  logic [4:0]  req_rd,
  output logic [5:0]  rb_raddr,
  input  logic [31:0] rb_rdata,
  output logic [5:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        rd_wen,
  output logic        done,
  output logic        illegal
);

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [5:0]  r_csr6;
  logic [1:0]  r_kind;
  logic [31:0] r_rs1;
  logic [4:0]  r_rd;
  logic        r_do_csr_wr;
  logic        r_illegal;
  logic [31:0] r_old;
  logic [31:0] r_new;

  logic        w_map_hit;
  logic [5:0]  w_map_addr;
  logic        w_map_ro;
  logic        w_accept;
  logic        w_do_csr_wr;
  logic        w_illegal;

  fwrisc_csr_map #(
    .ENABLE_COUNTERS (ENABLE_COUNTERS),
    .ENABLE_DEP      (ENABLE_DEP)
  ) u_map (
    .i_csr  (req_csr),
    .o_hit  (w_map_hit),
    .o_addr (w_map_addr),
    .o_ro   (w_map_ro)
  );

  assign w_accept    = req_valid && req_ready;
  // Set/clear with a zero operand must not touch the CSR at all
  assign w_do_csr_wr = (req_op[1:0] == 2'b01) || !req_rs1_zero;
  assign w_illegal   = !w_map_hit
                    || (req_op == OP_ILL0) || (req_op == OP_ILL4)
                    || (RV32E && req_rd[4])
                    || (w_do_csr_wr && w_map_ro);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = w_illegal ? ST_DONE : ST_READ;
      ST_READ:   w_state_nxt = ST_CAPT;
      ST_CAPT: begin
        if (r_do_csr_wr)         w_state_nxt = ST_WR_CSR;
        else if (r_rd != 5'd0)   w_state_nxt = ST_WR_GPR;
        else                     w_state_nxt = ST_DONE;
      end
      ST_WR_CSR: w_state_nxt = (r_rd != 5'd0) ? ST_WR_GPR : ST_DONE;
      ST_WR_GPR: w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_csr6      <= 6'd0;
      r_kind      <= 2'b00;
      r_rs1       <= 32'd0;
      r_rd        <= 5'd0;
      r_do_csr_wr <= 1'b0;
      r_illegal   <= 1'b0;
      r_old       <= 32'd0;
      r_new       <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_csr6      <= w_map_addr;
        r_kind      <= req_op[1:0];
        r_rs1       <= req_rs1_data;
        r_rd        <= req_rd;
        r_do_csr_wr <= w_do_csr_wr;
        r_illegal   <= w_illegal;
      end
      if (r_state == ST_CAPT) begin
        r_old <= rb_rdata;
        r_new <= csr_apply(r_kind, rb_rdata, r_rs1);
      end
    end
  end

  always_comb begin
    req_ready = (r_state == ST_IDLE);
    rb_raddr  = (r_state == ST_READ) ? r_csr6 : 6'd0;
    rd_wen    = 1'b0;
    rd_waddr  = 6'd0;
    rd_wdata  = 32'd0;
    done      = (r_state == ST_DONE);
    illegal   = (r_state == ST_DONE) && r_illegal;
    case (r_state)
      ST_WR_CSR: begin
        rd_wen   = 1'b1;
        rd_waddr = r_csr6;
        rd_wdata = r_new;
      end
      ST_WR_GPR: begin
        rd_wen   = 1'b1;
        rd_waddr = {1'b0, r_rd};
        rd_wdata = r_old;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
